mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter for the CPU6 system bus; replaces the bench's write-to-F200 print hack with a synthesizable peripheral.
- Buffers CPU writes in a FIFO and serialises them 8N1 on `txd` at a programmable bit rate.
- Exposes status and divisor registers, plus a level interrupt.
- Sits beside the Memory module on the shared address/data bus; the top-level read mux selects `data_out` when `hit` is 1.

Parameters:
- BASE_ADDR, 16'hF200, base of the 4-byte register window (must be 4-aligned).
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- CLK_DIV, 16'd16, reset value of the divisor register (clocks per bit).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  16  CPU address bus.
- write_en  in  1  CPU write strobe, sampled on the clock edge.
- data_in  in  8  CPU write data.
- data_out  out  8  register read data; combinational; 8'h00 when not hit.
- hit  out  1  combinational; 1 when address[15:2] == BASE_ADDR[15:2].
- txd  out  1  serial output; idle high.
- irq  out  1  level interrupt.

Behaviour:
- Register map (offset = address[1:0]):
  - +0 DATA: write pushes data_in into the FIFO; read returns 8'h00.
  - +1 STATUS, read: bit0 busy (FSM not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bit7 irq_en, other bits 0.
  - +1 STATUS, write: bit3=1 clears overflow; bit7 is loaded into irq_en.
  - +2 DIV_LO / +3 DIV_HI: read and write the 16-bit divisor. A divisor of 0 behaves as 1.
- Reset (reset low, asynchronous), all outputs and state:
  - txd=1, irq=0, FSM=IDLE.
  - FIFO empty, pointers 0, overflow=0, irq_en=0, divisor=CLK_DIV.
  - Any frame in flight is aborted immediately; txd returns high with no glitch low.
- FIFO: the write pointer is log2(FIFO_DEPTH)+1 bits, wrapping naturally; full and empty are decoded from the MSB comparison.
  - A push when not full is accepted.
  - A push when full is accepted only if a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow is set; FIFO contents are unchanged.
  - Simultaneous push and pop with the FIFO empty: the pop does not occur. The FSM sees the new entry on the next cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head into shift[7:0], load baud_cnt = divisor-1, bit_idx=0, go to START.
  - START: txd=0 for `divisor` clocks.
  - DATA: txd=shift[0] for `divisor` clocks per bit, LSB first; shift right at each bit end; after bit_idx 7 go to STOP.
  - STOP: txd=1 for `divisor` clocks, then IDLE.
  - Back-to-back frames: IDLE lasts exactly one clock between frames.
- txd is registered. For a DATA write on edge N into an empty FIFO with an idle FSM:
  - pop occurs on edge N+1;
  - txd falls at edge N+2;
  - one frame is 10×divisor clocks of line time.
- A divisor write takes effect at the next bit boundary (next baud_cnt reload); the current bit is not shortened.
- irq = irq_en & fifo_empty & ~busy, registered with one-cycle latency.
- Writes outside the window are ignored. Reads have no side effects.

Decomposition:
- Shared package: register offset constants (DATA/STATUS/DIV_LO/DIV_HI), STATUS bit positions, FSM state encodings.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty), reused later for RX.
- The FSM and register file stay in mmio_uart_tx.

Test Plan:
- Reset and readback: assert reset low mid-frame with CLK_DIV=4 -> txd=1 immediately; STATUS reads 8'h04; DIV_LO/HI read 8'h04/8'h00.
- Single byte: write 8'h55 to F200 with divisor=4 -> txd falls 2 clocks after the write edge; pattern 0,1,0,1,0,1,0,1,0,1 at 4 clocks per bit; busy clears after 40 clocks.
- Fill and overflow: with FIFO_DEPTH=4, write 6 bytes in consecutive cycles -> first pops at cycle 2; STATUS bit3=1; the 6th byte is never transmitted; writing 8'h08 to STATUS clears bit3.
- Back-to-back: write 8'h48, 8'h69 -> two contiguous frames with exactly one idle-high clock between the stop bit and the next start bit; decoded bytes are "Hi".
- Divisor change: during the DATA bits of a frame at divisor=4, write DIV_LO=8 -> the current bit stays 4 clocks and subsequent bits are 8 clocks.
- IRQ: write 8'h80 to STATUS, then send one byte -> irq=0 while busy; irq=1 one clock after busy clears; it drops when STATUS bit7 is written to 0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx shared definitions
// register offsets, status bits, tx states
package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV_LO = 2'd2;
  localparam logic [1:0] OFF_DIV_HI = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_IRQEN = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO
// extra pointer MSB tells full from empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign wptr_d  = do_push ? wptr_q + ONE : wptr_q;
  assign rptr_d  = do_pop  ? rptr_q + ONE : rptr_q;

  // storage write; contents need no reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  // pointer update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 transmitter
// FIFO-buffered writes, divisor and status regs
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hF200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] CLK_DIV    = 16'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        hit,
  output logic        txd,
  output logic        irq
);

  logic [1:0]  off;
  logic        wr, push;
  logic        fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [7:0]  fifo_rdata;
  logic [15:0] div_q, div_eff, reload;
  logic        ovf_q, irq_en_q, irq_q, txd_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        busy, bit_end;
  logic [7:0]  status;

  assign hit     = (address[15:2] == BASE_ADDR[15:2]);
  assign off     = address[1:0];
  assign wr      = hit & write_en;
  assign push    = wr & (off == OFF_DATA);
  assign busy    = (state_q != S_IDLE);
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign reload  = div_eff - 16'd1;
  assign bit_end = (baud_q == 16'd0);
  assign fifo_pop = (state_q == S_IDLE) & ~fifo_empty;
  assign txd     = txd_q;
  assign irq     = irq_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (data_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // status byte and read mux
  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = ovf_q;
    status[ST_IRQEN] = irq_en_q;
    data_out = 8'h00;
    if (hit) begin
      unique case (off)
        OFF_DATA:   data_out = 8'h00;
        OFF_STATUS: data_out = status;
        OFF_DIV_LO: data_out = div_q[7:0];
        OFF_DIV_HI: data_out = div_q[15:8];
        default:    data_out = 8'h00;
      endcase
    end
  end

  // register file writes and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q    <= CLK_DIV;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (fifo_drop) ovf_q <= 1'b1;
      if (wr) begin
        unique case (off)
          OFF_STATUS: begin
            if (data_in[ST_OVF]) ovf_q <= 1'b0;
            irq_en_q <= data_in[ST_IRQEN];
          end
          OFF_DIV_LO: div_q[7:0]  <= data_in;
          OFF_DIV_HI: div_q[15:8] <= data_in;
          default: ;
        endcase
      end
    end
  end

  // tx FSM next state; divisor sampled only on reload
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          shift_d   = fifo_rdata;
          baud_d    = reload;
          bit_idx_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = reload;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d    = reload;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
        else baud_d = baud_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, registered line and interrupt
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= (state_q == S_START) ? 1'b0 :
                   (state_q == S_DATA)  ? shift_q[0] : 1'b1;
      irq_q     <= irq_en_q & fifo_empty & ~busy;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench
// line monitor decodes frames vs expected queue
module tb_mmio_uart_tx;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        hit, txd, irq;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 0;
  int   lens [10];
  exp_t sb [$];

  mmio_uart_tx #(
    .BASE_ADDR  (16'hF200),
    .FIFO_DEPTH (4),
    .CLK_DIV    (16'd4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .hit      (hit),
    .txd      (txd),
    .irq      (irq)
  );

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address  = a;
    data_in  = d;
    write_en = 1;
    @(negedge clock);
    write_en = 0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  // line monitor: sample each bit cell at negedges
  int         m_st;
  logic [7:0] m_b;
  logic       m_ok, m_v;
  exp_t       m_e;
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && reset && txd === 1'b0) begin
        m_st = cyc;
        m_ok = 1;
        m_b  = '0;
        m_v  = 0;
        for (int k = 0; k < 10; k++) begin
          for (int j = 0; j < lens[k]; j++) begin
            if (k != 0 || j != 0) @(negedge clock);
            if (j == 0) m_v = txd;
            else if (txd !== m_v) m_ok = 0;
            if (j == 0 && k >= 1 && k <= 8) m_b[k-1] = txd;
            if (j == 0 && k == 9 && txd !== 1'b1) m_ok = 0;
          end
        end
        chk("frame_shape", m_ok, 1);
        if (sb.size() == 0) begin
          chk("unexpected_frame", m_b, 32'hFFFF);
        end else begin
          m_e = sb.pop_front();
          chk("rx_byte", m_b, m_e.data);
          if (m_e.start >= 0) chk("start_cyc", m_st, m_e.start);
        end
      end
    end
  end

  logic [7:0] r;
  int         w;
  logic       ok;

  initial begin
    foreach (lens[i]) lens[i] = 4;
    reset = 0; address = 0; write_en = 0; data_in = 0;
    repeat (2) @(negedge clock);
    chk("rst_txd", txd, 1);
    chk("rst_irq", irq, 0);
    reset = 1;
    @(negedge clock);

    // reset mid-frame
    wr(16'hF200, 8'hF0);
    repeat (8) @(negedge clock);
    chk("pre_rst_txd", txd, 0);
    #2 reset = 0;
    #1 chk("async_rst_txd", txd, 1);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    rd(16'hF201, r); chk("rst_status", r, 8'h04);
    rd(16'hF202, r); chk("rst_div_lo", r, 8'h04);
    rd(16'hF203, r); chk("rst_div_hi", r, 8'h00);
    chk("rst_irq2", irq, 0);
    chk("hit_in", hit, 1);
    rd(16'hF200, r); chk("data_rd", r, 8'h00);
    rd(16'h1234, r);
    chk("hit_out", hit, 0);
    chk("miss_rd", r, 8'h00);
    rd(16'hF1FF, r); chk("edge_miss", hit, 0);
    mon_en = 1;
    @(negedge clock);

    // single byte
    wr(16'hF200, 8'h55);
    w = cyc;
    sb.push_back('{8'h55, w + 2});
    chk("txd_hold1", txd, 1);
    @(negedge clock);
    chk("txd_hold2", txd, 1);
    @(negedge clock);
    chk("txd_fall", txd, 0);
    while (cyc < w + 40) @(negedge clock);
    rd(16'hF201, r); chk("busy_39", r[0], 1);
    @(negedge clock);
    rd(16'hF201, r); chk("busy_40", r[0], 0);
    drain();

    // fill and overflow
    wr(16'hF200, 8'h11);
    w = cyc;
    wr(16'hF200, 8'h22);
    wr(16'hF200, 8'h33);
    wr(16'hF200, 8'h44);
    wr(16'hF200, 8'h55);
    wr(16'hF200, 8'h66);
    sb.push_back('{8'h11, w + 2});
    sb.push_back('{8'h22, w + 43});
    sb.push_back('{8'h33, w + 84});
    sb.push_back('{8'h44, w + 125});
    sb.push_back('{8'h55, w + 166});
    rd(16'hF201, r); chk("ovf_status", r, 8'h0B);
    wr(16'hF201, 8'h08);
    rd(16'hF201, r); chk("ovf_clear", r, 8'h03);
    drain();

    // back-to-back "Hi"
    wr(16'hF200, 8'h48);
    w = cyc;
    wr(16'hF200, 8'h69);
    sb.push_back('{8'h48, w + 2});
    sb.push_back('{8'h69, w + 43});
    drain();

    // divisor change mid-frame
    for (int i = 2; i < 10; i++) lens[i] = 8;
    wr(16'hF200, 8'hA5);
    w = cyc;
    sb.push_back('{8'hA5, w + 2});
    repeat (6) @(negedge clock);
    wr(16'hF202, 8'h08);
    rd(16'hF202, r); chk("div_rd", r, 8'h08);
    drain();
    wr(16'hF202, 8'h04);
    foreach (lens[i]) lens[i] = 4;

    // interrupt
    wr(16'hF201, 8'h80);
    chk("irq_lat0", irq, 0);
    @(negedge clock);
    chk("irq_idle", irq, 1);
    wr(16'hF200, 8'h3C);
    w = cyc;
    sb.push_back('{8'h3C, w + 2});
    ok = 1;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clock);
      if (irq !== 1'b0) ok = 0;
    end
    chk("irq_busy_low", ok, 1);
    @(negedge clock);
    chk("irq_after", irq, 1);
    drain();
    wr(16'hF201, 8'h00);
    chk("irq_lat1", irq, 1);
    @(negedge clock);
    chk("irq_off", irq, 0);
    rd(16'hF201, r); chk("final_status", r, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
